// File: rtl/axil_user_arbiter_if.sv
// Requester-side and AXI-Lite user-port signals of the arbiter. The master modport is the arbiter;
// the slave modport is the environment (requesters plus the AXI-Lite master it drives).
interface axil_user_arbiter_if #(
   parameter int NREQ = 2,
   parameter int AW   = 32,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err;
   logic               write;
   logic               read;
   logic [AW-1:0]      user_waddr;
   logic [DW-1:0]      user_wdata;
   logic [AW-1:0]      user_raddr;
   logic [DW-1:0]      user_rdata;
   logic               wr_ready;
   logic               rd_ready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, user_rdata, wr_ready, rd_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, write, read, user_waddr, user_wdata, user_raddr
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, user_rdata, wr_ready, rd_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, write, read, user_waddr, user_wdata, user_raddr
   );
endinterface

// File: rtl/axil_user_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite user port among NREQ requesters, one transaction at a time.
// Strobe rises 1 cycle after accept; strobe held until matching ready or TIMEOUT busy cycles (error response).
module axil_user_arbiter #(
   parameter int NREQ    = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
) (
   input logic                 clk,
   input logic                 resetn,
   axil_user_arbiter_if.master bus
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GNT_RESET = GW'(NREQ - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   last_q, last_d;
   logic [GW-1:0]   gnt_q, gnt_d;
   logic            dir_q, dir_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] req_ready_q, req_ready_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;
   logic            write_q, write_d;
   logic            read_q, read_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [AW-1:0]   raddr_q, raddr_d;

   logic            pick_vld;
   logic [GW-1:0]   pick;
   logic [GW-1:0]   scan;
   logic            done;

   // Scan from farthest to nearest so the first hit after last_q is the one that sticks.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      scan     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         scan = GW'((int'(last_q) + k) % NREQ);
         if (bus.req_valid[scan]) begin
            pick_vld = 1'b1;
            pick     = scan;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      write_d     = write_q;
      read_d      = read_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      raddr_d     = raddr_q;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d           = BUSY;
               last_d            = pick;
               gnt_d             = pick;
               dir_d             = bus.req_write[pick];
               cnt_d             = '0;
               req_ready_d[pick] = 1'b1;
               if (bus.req_write[pick]) begin
                  write_d = 1'b1;
                  waddr_d = bus.req_addr[int'(pick)*AW +: AW];
                  wdata_d = bus.req_wdata[int'(pick)*DW +: DW];
               end else begin
                  read_d  = 1'b1;
                  raddr_d = bus.req_addr[int'(pick)*AW +: AW];
               end
            end
         end
         BUSY: begin
            // Only the ready matching the latched direction completes; completion beats timeout.
            done = dir_q ? bus.wr_ready : bus.rd_ready;
            if (done || (cnt_q == CNT_LAST)) begin
               state_d            = IDLE;
               write_d            = 1'b0;
               read_d             = 1'b0;
               cnt_d              = '0;
               rsp_valid_d[gnt_q] = 1'b1;
               rsp_err_d          = !done;
               rsp_rdata_d        = (done && !dir_q) ? bus.user_rdata : '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         last_q      <= GNT_RESET;
         gnt_q       <= '0;
         dir_q       <= 1'b0;
         cnt_q       <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         raddr_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         write_q     <= write_d;
         read_q      <= read_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         raddr_q     <= raddr_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.write      = write_q;
   assign bus.read       = read_q;
   assign bus.user_waddr = waddr_q;
   assign bus.user_wdata = wdata_q;
   assign bus.user_raddr = raddr_q;
endmodule

// File: tb/tb_axil_user_arbiter.sv
// Randomised bench for axil_user_arbiter: requester drivers, an AXI-Lite responder and a monitor
// that checks grants, strobes and responses against a transaction-level round-robin model.
module tb_axil_user_arbiter;
   localparam int NREQ    = 2;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct {
      int            len;
      logic          err;
      logic [DW-1:0] rdata;
   } rsp_t;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   axil_user_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   axil_user_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   txn_t pend [NREQ][$];
   rsp_t expq [$];
   int   grant_log [$];

   bit            mon_en      = 1'b0;
   int            force_delay = -1;
   bit            force_rd_en = 1'b0;
   logic [DW-1:0] force_rd    = '0;
   bit            wrong_all   = 1'b0;
   bit            gap_en      = 1'b0;
   int            err_rsps    = 0;

   // model state
   int              ptr;
   int              cur_id;
   bit              inflight;
   txn_t            cur;
   int              len;
   bit              prev_idle;
   logic [NREQ-1:0] prev_valid;
   txn_t            prev_txn [NREQ];
   logic [DW-1:0]   m_rdata;
   logic            m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: expected event did not occur", name);
   endtask

   function automatic int pick_rr(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return 0;
   endfunction

   function automatic bit pend_empty();
      for (int i = 0; i < NREQ; i++) begin
         if (pend[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // ---------------- requester drivers ----------------
   txn_t drv_t;
   initial begin
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && pend[i].size() != 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
               drv_t = pend[i].pop_front();
               bus.req_valid[i]           = 1'b1;
               bus.req_write[i]           = drv_t.wr;
               bus.req_addr[i*AW +: AW]   = drv_t.addr;
               bus.req_wdata[i*DW +: DW]  = drv_t.wdata;
            end
         end
      end
   end

   // ---------------- AXI-Lite responder ----------------
   bit            rs_was;
   bit            rs_wr;
   int            rs_d;
   int            rs_k;
   logic [DW-1:0] rs_data;
   rsp_t          rs_r;
   initial begin
      bus.wr_ready   = 1'b0;
      bus.rd_ready   = 1'b0;
      bus.user_rdata = '0;
      rs_was         = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if ((bus.write || bus.read) && !rs_was) begin
            rs_wr = bus.write;
            if (force_delay >= 0) rs_d = force_delay;
            else rs_d = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 4);
            rs_data    = force_rd_en ? force_rd : DW'($urandom);
            rs_r.err   = (rs_d >= TIMEOUT);
            rs_r.len   = rs_r.err ? TIMEOUT : rs_d + 1;
            rs_r.rdata = (rs_r.err || rs_wr) ? '0 : rs_data;
            expq.push_back(rs_r);
            rs_k = 0;
            do begin
               bus.wr_ready   = 1'b0;
               bus.rd_ready   = 1'b0;
               bus.user_rdata = DW'($urandom);
               if (rs_k == rs_d) begin
                  if (rs_wr) bus.wr_ready = 1'b1;
                  else bus.rd_ready = 1'b1;
                  bus.user_rdata = rs_data;
               end else if (wrong_all || $urandom_range(0, 3) == 0) begin
                  if (rs_wr) bus.rd_ready = 1'b1;
                  else bus.wr_ready = 1'b1;
               end
               @(posedge clk);
               #1;
               rs_k++;
            end while ((bus.write || bus.read) && rs_k < TIMEOUT + 4);
            bus.wr_ready = 1'b0;
            bus.rd_ready = 1'b0;
         end
         rs_was = bus.write || bus.read;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   rsp_t            mon_e;
   logic [NREQ-1:0] mon_exp;
   logic [NREQ-1:0] mon_oh;
   int              mon_g;
   always @(negedge clk) begin
      if (!mon_en) begin
         ptr       = NREQ - 1;
         inflight  = 1'b0;
         prev_idle = 1'b1;
         m_rdata   = '0;
         m_err     = 1'b0;
         expq.delete();
      end else begin
         if (bus.rsp_valid != '0) begin
            if (!inflight || expq.size() == 0) begin
               chk("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
            end else begin
               mon_e  = expq.pop_front();
               mon_oh = '0;
               mon_oh[cur_id] = 1'b1;
               chk("rsp_valid_id", 64'(bus.rsp_valid), 64'(mon_oh));
               chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
               chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
               chk("busy_cycles", 64'(len), 64'(mon_e.len));
               m_rdata = mon_e.rdata;
               m_err   = mon_e.err;
               if (mon_e.err) err_rsps++;
            end
            inflight = 1'b0;
         end else begin
            chk("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(m_rdata));
            chk("rsp_err_hold", 64'(bus.rsp_err), 64'(m_err));
         end

         mon_exp = '0;
         mon_g   = 0;
         if (prev_idle && prev_valid != '0) begin
            mon_g          = pick_rr(prev_valid, ptr);
            mon_exp[mon_g] = 1'b1;
         end
         if (mon_exp != '0 || bus.req_ready != '0)
            chk("req_ready", 64'(bus.req_ready), 64'(mon_exp));
         if (mon_exp != '0) begin
            ptr      = mon_g;
            cur_id   = mon_g;
            cur      = prev_txn[mon_g];
            inflight = 1'b1;
            len      = 0;
            grant_log.push_back(mon_g);
         end

         if (inflight) begin
            len++;
            chk("write_strobe", 64'(bus.write), 64'(cur.wr));
            chk("read_strobe", 64'(bus.read), 64'(!cur.wr));
            if (cur.wr) begin
               chk("user_waddr", 64'(bus.user_waddr), 64'(cur.addr));
               chk("user_wdata", 64'(bus.user_wdata), 64'(cur.wdata));
            end else begin
               chk("user_raddr", 64'(bus.user_raddr), 64'(cur.addr));
            end
            if (len > TIMEOUT) begin
               fail_now("rsp_missing");
               inflight = 1'b0;
            end
         end else if (bus.write || bus.read) begin
            chk("strobe_idle", 64'({bus.write, bus.read}), 64'd0);
         end
         prev_idle = !inflight;
      end
      prev_valid = bus.req_valid;
      for (int i = 0; i < NREQ; i++) begin
         prev_txn[i].wr    = bus.req_write[i];
         prev_txn[i].addr  = bus.req_addr[i*AW +: AW];
         prev_txn[i].wdata = bus.req_wdata[i*DW +: DW];
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (n < 3000 && !(pend_empty() && bus.req_valid == '0 && !inflight && !bus.write && !bus.read)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now(name);
      repeat (2) @(negedge clk);
   endtask

   task automatic push_txn(input int id, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      txn_t t;
      t.wr    = wr;
      t.addr  = addr;
      t.wdata = wdata;
      pend[id].push_back(t);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the end of the run");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_write", 64'(bus.write), 64'd0);
      chk("rst_read", 64'(bus.read), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_user_waddr", 64'(bus.user_waddr), 64'd0);
      chk("rst_user_wdata", 64'(bus.user_wdata), 64'd0);
      chk("rst_user_raddr", 64'(bus.user_raddr), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      mon_en = 1'b1;

      // write from requester 0, wr_ready 3 cycles after the strobe rises
      @(negedge clk);
      force_delay = 3;
      push_txn(0, 1'b1, 32'h0, 32'h0000_1234);
      wait_idle("t_write_done");

      // read from requester 1 with fixed read data
      force_delay = 2;
      force_rd_en = 1'b1;
      force_rd    = 32'hA5A5_00FF;
      push_txn(1, 1'b0, 32'h4, 32'h0);
      wait_idle("t_read_done");
      force_rd_en = 1'b0;

      // both requesters continuously valid: grants must alternate starting at 0
      grant_log.delete();
      force_delay = 1;
      push_txn(0, 1'b1, 32'h10, 32'h1111_0000);
      push_txn(0, 1'b0, 32'h14, 32'h0);
      push_txn(1, 1'b0, 32'h20, 32'h0);
      push_txn(1, 1'b1, 32'h24, 32'h2222_0000);
      wait_idle("t_rr_done");
      chk("rr_count", 64'(grant_log.size()), 64'd4);
      if (grant_log.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 2));
      end

      // timeout on a read, then a normal transaction
      force_delay = TIMEOUT;
      push_txn(1, 1'b0, 32'h30, 32'h0);
      wait_idle("t_timeout_done");
      chk("timeout_err_seen", 64'(err_rsps), 64'd1);
      force_delay = 2;
      push_txn(0, 1'b1, 32'h34, 32'hCAFE_0001);
      wait_idle("t_after_timeout_done");

      // matching ready on the last allowed cycle: completion wins
      force_delay = TIMEOUT - 1;
      push_txn(0, 1'b0, 32'h38, 32'h0);
      wait_idle("t_edge_done");
      chk("edge_no_err", 64'(err_rsps), 64'd1);

      // wrong-direction ready pulsed every cycle while a write and a read are in flight
      wrong_all   = 1'b1;
      force_delay = 4;
      push_txn(1, 1'b1, 32'h40, 32'hDEAD_BEEF);
      wait_idle("t_wrong_wr_done");
      push_txn(0, 1'b0, 32'h44, 32'h0);
      wait_idle("t_wrong_rd_done");
      wrong_all = 1'b0;

      // random traffic
      force_delay = -1;
      gap_en      = 1'b1;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < NREQ; i++)
            push_txn(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      wait_idle("t_random_done");
      gap_en = 1'b0;

      // reset while a read from requester 0 is in flight
      force_delay = TIMEOUT;
      push_txn(0, 1'b0, 32'h50, 32'h0);
      begin
         int n;
         n = 0;
         while (!bus.read && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) fail_now("t_midrst_strobe");
      end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      resetn = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_write", 64'(bus.write), 64'd0);
      chk("midrst_read", 64'(bus.read), 64'd0);
      chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      chk("midrst_rsp_valid2", 64'(bus.rsp_valid), 64'd0);
      grant_log.delete();
      force_delay = 1;
      push_txn(1, 1'b1, 32'h60, 32'h6666_0000);
      push_txn(0, 1'b1, 32'h64, 32'h7777_0000);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      mon_en = 1'b1;
      wait_idle("t_midrst_done");
      chk("midrst_grants", 64'(grant_log.size()), 64'd2);
      if (grant_log.size() != 0) chk("midrst_first_grant", 64'(grant_log[0]), 64'd0);

      chk("scoreboard_empty", 64'(expq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
